// File: rtl/dbg_uart.sv
// Debug command engine: parses byte commands from a UART receiver and drives a
// 16-bit debug memory port, sending read/status responses with inter-byte pacing.
module dbg_uart #(
  parameter int unsigned GAP = 4500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dix,
  input  logic [7:0]  id,
  output logic        dox,
  output logic [7:0]  od,
  output logic        csu,
  output logic [15:0] addru,
  output logic        ru,
  output logic [1:0]  wru,
  input  logic [15:0] data,
  output logic [15:0] datau,
  input  logic [7:0]  status
);

  localparam int unsigned GapW = $clog2(GAP + 2);

  localparam logic [7:0] OpSetAddr = 8'h01;
  localparam logic [7:0] OpWrite   = 8'h02;
  localparam logic [7:0] OpWriteB  = 8'h03;
  localparam logic [7:0] OpRead    = 8'h04;
  localparam logic [7:0] OpStatus  = 8'h05;
  localparam logic [7:0] OpStop    = 8'h06;
  localparam logic [7:0] OpGo      = 8'h07;

  typedef enum logic [2:0] {
    StIdle, StArg1, StArg2, StPre, StAcc, StPost, StStat, StTx
  } state_e;

  state_e          state_q;
  logic [7:0]      cmd_q;
  logic [7:0]      hi_q;
  logic            halt_q;
  logic [15:0]     tx_q;
  logic [1:0]      tx_cnt_q;
  logic [GapW-1:0] gap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cmd_q    <= 8'h00;
      hi_q     <= 8'h00;
      halt_q   <= 1'b0;
      tx_q     <= 16'h0000;
      tx_cnt_q <= 2'd0;
      gap_q    <= '0;
      dox      <= 1'b0;
      od       <= 8'h00;
      csu      <= 1'b0;
      addru    <= 16'h0000;
      ru       <= 1'b0;
      wru      <= 2'b00;
      datau    <= 16'h0000;
    end else begin
      dox <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;

      unique case (state_q)
        StIdle: begin
          if (dix) begin
            cmd_q <= id;
            case (id)
              OpSetAddr, OpWrite: state_q <= StArg1;
              OpWriteB:           state_q <= StArg2;
              OpRead: begin
                state_q <= StPre;
                csu     <= 1'b1;
              end
              OpStatus:           state_q <= StStat;
              OpStop: begin
                halt_q <= 1'b1;
                csu    <= 1'b1;
              end
              OpGo: begin
                halt_q <= 1'b0;
                csu    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        StArg1: begin
          if (dix) begin
            hi_q    <= id;
            state_q <= StArg2;
          end
        end
        StArg2: begin
          if (dix) begin
            if (cmd_q == OpSetAddr) begin
              addru   <= {hi_q, id};
              state_q <= StIdle;
            end else begin
              datau   <= (cmd_q == OpWrite) ? {hi_q, id} : {id, id};
              csu     <= 1'b1;
              state_q <= StPre;
            end
          end
        end
        // csu is already high here, so the strobe below never leads the bus grant.
        StPre: begin
          if (cmd_q == OpRead)       ru  <= 1'b1;
          else if (cmd_q == OpWrite) wru <= 2'b11;
          else                       wru <= addru[0] ? 2'b01 : 2'b10;
          state_q <= StAcc;
        end
        StAcc: begin
          ru  <= 1'b0;
          wru <= 2'b00;
          if (cmd_q == OpRead) begin
            tx_q     <= data;
            tx_cnt_q <= 2'd2;
          end
          addru   <= addru + ((cmd_q == OpWriteB) ? 16'd1 : 16'd2);
          state_q <= StPost;
        end
        StPost: begin
          csu     <= halt_q;
          state_q <= (cmd_q == OpRead) ? StTx : StIdle;
        end
        StStat: begin
          tx_q     <= {status, 8'h00};
          tx_cnt_q <= 2'd1;
          state_q  <= StTx;
        end
        StTx: begin
          if (gap_q == '0) begin
            dox      <= 1'b1;
            od       <= tx_q[15:8];
            tx_q     <= {tx_q[7:0], 8'h00};
            gap_q    <= GapW'(GAP);
            tx_cnt_q <= tx_cnt_q - 2'd1;
            if (tx_cnt_q == 2'd1) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart.sv
// Bench for dbg_uart: directed command table, hand-built corner sequences and
// random commands scored against a command-level model of the debugger.
module tb_dbg_uart;

  localparam int unsigned GAP = 16;
  localparam int WaitMax = 4 * GAP + 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dix = 1'b0;
  logic [7:0]  id = 8'h00;
  logic        dox;
  logic [7:0]  od;
  logic        csu;
  logic [15:0] addru;
  logic        ru;
  logic [1:0]  wru;
  logic [15:0] data = 16'h0000;
  logic [15:0] datau;
  logic [7:0]  status = 8'h00;

  always #5 clk = ~clk;

  dbg_uart #(.GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .dix   (dix),
    .id    (id),
    .dox   (dox),
    .od    (od),
    .csu   (csu),
    .addru (addru),
    .ru    (ru),
    .wru   (wru),
    .data  (data),
    .datau (datau),
    .status(status)
  );

  typedef struct {
    logic        ru;
    logic [1:0]  wru;
    logic [15:0] addr;
    logic [15:0] dat;
  } acc_t;

  typedef struct {
    int          nb;
    logic [7:0]  b0, b1, b2;
    logic [15:0] din;
    logic [7:0]  st;
    logic [15:0] e_addr;
    logic [15:0] e_datau;
    logic        e_csu;
    int          e_nacc;
    logic        e_ru;
    logic [1:0]  e_wru;
    logic [15:0] e_acc_addr;
    int          e_ntx;
    logic [7:0]  e_tx0, e_tx1;
  } vec_t;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int cyc = 0;
  acc_t       acc_log[$];
  logic [7:0] tx_log[$];

  // Protocol monitor: bus-grant framing, strobe exclusivity, dox pacing, od hold.
  logic csu_prev = 1'b0, acc_prev = 1'b0, have_last = 1'b0;
  int last_cyc = 0;
  logic [7:0] last_od = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      have_last <= 1'b0;
      csu_prev  <= 1'b0;
      acc_prev  <= 1'b0;
    end else begin
      if (ru || wru != 2'b00) begin
        acc_log.push_back('{ru, wru, addru, datau});
        if (!csu || !csu_prev || (ru && wru != 2'b00)) viol <= viol + 1;
      end
      if (acc_prev && !csu) viol <= viol + 1;
      acc_prev <= ru || (wru != 2'b00);
      csu_prev <= csu;
      if (dox) begin
        tx_log.push_back(od);
        if (have_last && (cyc - last_cyc) < int'(GAP)) viol <= viol + 1;
        last_cyc  <= cyc;
        have_last <= 1'b1;
        last_od   <= od;
      end else if (have_last && od != last_od) begin
        viol <= viol + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    @(posedge clk);
    #1;
    dix = 1'b1;
    id  = b;
    @(posedge clk);
    #1;
    dix = 1'b0;
    repeat (idle) @(posedge clk);
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_log.size() < n && t < WaitMax) begin
      @(posedge clk);
      t++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    acc_log.delete();
    tx_log.delete();
    data   = v.din;
    status = v.st;
    send_byte(v.b0, $urandom_range(0, 3));
    if (v.nb > 1) send_byte(v.b1, $urandom_range(0, 3));
    if (v.nb > 2) send_byte(v.b2, 0);
    wait_tx(v.e_ntx);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk({tag, ".addru"}, 32'(addru), 32'(v.e_addr));
    chk({tag, ".datau"}, 32'(datau), 32'(v.e_datau));
    chk({tag, ".csu"}, 32'(csu), 32'(v.e_csu));
    chk({tag, ".n_access"}, 32'(acc_log.size()), 32'(v.e_nacc));
    if (acc_log.size() > 0 && v.e_nacc > 0) begin
      chk({tag, ".ru"}, 32'(acc_log[0].ru), 32'(v.e_ru));
      chk({tag, ".wru"}, 32'(acc_log[0].wru), 32'(v.e_wru));
      chk({tag, ".acc_addr"}, 32'(acc_log[0].addr), 32'(v.e_acc_addr));
      chk({tag, ".acc_datau"}, 32'(acc_log[0].dat), 32'(v.e_datau));
    end
    chk({tag, ".n_tx"}, 32'(tx_log.size()), 32'(v.e_ntx));
    if (tx_log.size() > 0 && v.e_ntx > 0) chk({tag, ".tx0"}, 32'(tx_log[0]), 32'(v.e_tx0));
    if (tx_log.size() > 1 && v.e_ntx > 1) chk({tag, ".tx1"}, 32'(tx_log[1]), 32'(v.e_tx1));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
    dix   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, ".csu"}, 32'(csu), 32'd0);
    chk({tag, ".addru"}, 32'(addru), 32'd0);
    chk({tag, ".datau"}, 32'(datau), 32'd0);
    chk({tag, ".ru_wru"}, 32'({ru, wru}), 32'd0);
    chk({tag, ".dox_od"}, 32'({dox, od}), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  // Command-level model state for random runs.
  logic [15:0] m_addr, m_datau;
  logic        m_halt;

  task automatic build_random(output vec_t v);
    int k = $urandom_range(0, 7);
    v = '{1, 8'h00, 8'h00, 8'h00, 16'h0, 8'h0, 16'h0, 16'h0, 1'b0, 0, 1'b0, 2'b00, 16'h0,
          0, 8'h0, 8'h0};
    v.b0  = (k == 0) ? 8'($urandom_range(8, 255)) : 8'(k);
    v.b1  = 8'($urandom);
    v.b2  = 8'($urandom);
    v.din = 16'($urandom);
    v.st  = 8'($urandom);
    case (k)
      1: begin
        v.nb = 3;
        m_addr = {v.b1, v.b2};
      end
      2: begin
        v.nb = 3;
        v.e_nacc = 1; v.e_wru = 2'b11; v.e_acc_addr = m_addr;
        m_datau = {v.b1, v.b2};
        m_addr = m_addr + 16'd2;
      end
      3: begin
        v.nb = 2;
        v.e_nacc = 1; v.e_wru = (m_addr % 2 == 0) ? 2'b10 : 2'b01; v.e_acc_addr = m_addr;
        m_datau = {v.b1, v.b1};
        m_addr = m_addr + 16'd1;
      end
      4: begin
        v.e_nacc = 1; v.e_ru = 1'b1; v.e_acc_addr = m_addr;
        v.e_ntx = 2; v.e_tx0 = v.din[15:8]; v.e_tx1 = v.din[7:0];
        m_addr = m_addr + 16'd2;
      end
      5: begin
        v.e_ntx = 1; v.e_tx0 = v.st;
      end
      6: m_halt = 1'b1;
      7: m_halt = 1'b0;
      default: ;
    endcase
    v.e_addr  = m_addr;
    v.e_datau = m_datau;
    v.e_csu   = m_halt;
  endtask

  vec_t vecs[18];

  initial begin
    vec_t rv;
    //          nb b0     b1     b2     din       st     addr      datau     csu nacc ru wru
    //          acc_addr  ntx tx0  tx1
    vecs[0]  = '{3, 8'h01, 8'h12, 8'h34, 16'h0, 8'h00, 16'h1234, 16'h0000, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[1]  = '{3, 8'h01, 8'h00, 8'h10, 16'h0, 8'h00, 16'h0010, 16'h0000, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[2]  = '{3, 8'h02, 8'hAB, 8'hCD, 16'h0, 8'h00, 16'h0012, 16'hABCD, 0, 1, 0, 2'b11,
                 16'h0010, 0, 8'h0, 8'h0};
    vecs[3]  = '{3, 8'h01, 8'h00, 8'h11, 16'h0, 8'h00, 16'h0011, 16'hABCD, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[4]  = '{2, 8'h03, 8'h5A, 8'h00, 16'h0, 8'h00, 16'h0012, 16'h5A5A, 0, 1, 0, 2'b01,
                 16'h0011, 0, 8'h0, 8'h0};
    vecs[5]  = '{3, 8'h01, 8'h20, 8'h00, 16'h0, 8'h00, 16'h2000, 16'h5A5A, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[6]  = '{1, 8'h04, 8'h00, 8'h00, 16'hBEEF, 8'h00, 16'h2002, 16'h5A5A, 0, 1, 1, 2'b00,
                 16'h2000, 2, 8'hBE, 8'hEF};
    vecs[7]  = '{1, 8'h06, 8'h00, 8'h00, 16'h0, 8'h00, 16'h2002, 16'h5A5A, 1, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[8]  = '{1, 8'h05, 8'h00, 8'h00, 16'h0, 8'h21, 16'h2002, 16'h5A5A, 1, 0, 0, 2'b00,
                 16'h0, 1, 8'h21, 8'h0};
    vecs[9]  = '{1, 8'h07, 8'h00, 8'h00, 16'h0, 8'h00, 16'h2002, 16'h5A5A, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[10] = '{3, 8'h01, 8'hFF, 8'hFF, 16'h0, 8'h00, 16'hFFFF, 16'h5A5A, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[11] = '{2, 8'h03, 8'h77, 8'h00, 16'h0, 8'h00, 16'h0000, 16'h7777, 0, 1, 0, 2'b01,
                 16'hFFFF, 0, 8'h0, 8'h0};
    vecs[12] = '{3, 8'h01, 8'hFF, 8'hFE, 16'h0, 8'h00, 16'hFFFE, 16'h7777, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[13] = '{3, 8'h02, 8'h12, 8'h34, 16'h0, 8'h00, 16'h0000, 16'h1234, 0, 1, 0, 2'b11,
                 16'hFFFE, 0, 8'h0, 8'h0};
    vecs[14] = '{1, 8'h09, 8'h00, 8'h00, 16'h0, 8'h00, 16'h0000, 16'h1234, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[15] = '{3, 8'h01, 8'hFF, 8'hFE, 16'h0, 8'h00, 16'hFFFE, 16'h1234, 0, 0, 0, 2'b00,
                 16'h0, 0, 8'h0, 8'h0};
    vecs[16] = '{1, 8'h04, 8'h00, 8'h00, 16'h0F1E, 8'h00, 16'h0000, 16'h1234, 0, 1, 1, 2'b00,
                 16'hFFFE, 2, 8'h0F, 8'h1E};
    vecs[17] = '{2, 8'h03, 8'hC3, 8'h00, 16'h0, 8'h00, 16'h0001, 16'hC3C3, 0, 1, 0, 2'b10,
                 16'h0000, 0, 8'h0, 8'h0};

    do_reset("reset0");

    for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Operands survive long idle gaps between bytes.
    send_byte(8'h01, 60);
    send_byte(8'hAB, 60);
    send_byte(8'hCD, 4);
    @(negedge clk);
    chk("idle_gap.addru", 32'(addru), 32'h0000ABCD);

    // A STOP arriving mid-response must be ignored.
    acc_log.delete();
    tx_log.delete();
    data = 16'h1122;
    send_byte(8'h04, 0);
    wait_tx(1);
    send_byte(8'h06, 0);
    wait_tx(2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_dix.n_tx", 32'(tx_log.size()), 32'd2);
    chk("busy_dix.csu", 32'(csu), 32'd0);
    if (tx_log.size() == 2) chk("busy_dix.bytes", 32'({tx_log[0], tx_log[1]}), 32'h1122);

    // Reset between the two bytes of a read response cancels the second one.
    tx_log.delete();
    data = 16'h3344;
    send_byte(8'h04, 0);
    wait_tx(1);
    do_reset("reset_mid");
    repeat (4 * GAP) @(posedge clk);
    @(negedge clk);
    chk("reset_mid.n_tx", 32'(tx_log.size()), 32'd1);

    m_addr  = 16'h0000;
    m_datau = 16'h0000;
    m_halt  = 1'b0;
    do_reset("reset_rand");
    for (int i = 0; i < 60; i++) begin
      build_random(rv);
      run_vec(rv, $sformatf("rand%0d_op%0h", i, rv.b0));
    end

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_uart.md
DBG_UART -- requirements
Module: dbg_uart

Interface
REQ-001 SHALL have parameter GAP, default 4500, the minimum clock cycles between successive transmit strobes (one 10-bit frame at 115200 baud at 50 MHz, plus margin).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dix, input, 1 bit: one-cycle strobe; a received byte is valid on id.
REQ-005 SHALL have port dox, output, 1 bit: one-cycle strobe; the byte on od is to be transmitted.
REQ-006 SHALL have port id, input, 8 bits: received byte.
REQ-007 SHALL have port od, output, 8 bits: byte to transmit.
REQ-008 SHALL have port csu, output, 1 bit: debugger owns the bus and the CPU is stalled.
REQ-009 SHALL have port addru, output, 16 bits: debug byte address.
REQ-010 SHALL have port ru, output, 1 bit: read strobe.
REQ-011 SHALL have port wru, output, 2 bits: byte write enables; [1] is the high byte (even address), [0] is the low byte (odd address).
REQ-012 SHALL have port data, input, 16 bits: read data from memory.
REQ-013 SHALL have port datau, output, 16 bits: write data.
REQ-014 SHALL have port status, input, 8 bits: status byte returned on request.

Function
REQ-015 SHALL parse received bytes as commands: the byte arriving in idle is the opcode; any operand bytes follow, MSB first.
REQ-016 SHALL implement opcode 0x01 SETADDR: two operand bytes (hi, lo) are loaded into addru.
REQ-017 SHALL implement opcode 0x02 WRITE: two operand bytes (hi, lo) are loaded into datau; then one cycle with wru=2'b11 and csu=1; then addru += 2.
REQ-018 SHALL implement opcode 0x03 WRITEB: one operand byte b gives datau={b,b}; wru=2'b10 if addru[0]=0, else 2'b01, for one cycle; then addru += 1.
REQ-019 SHALL implement opcode 0x04 READ: ru=1 and csu=1 for one cycle; data is sampled on the clock edge that ends that cycle; data[15:8] and then data[7:0] are transmitted; addru += 2.
REQ-020 SHALL implement opcode 0x05 STATUS: status is sampled on the cycle after the opcode and transmitted as one byte.
REQ-021 SHALL implement opcode 0x06 STOP (halt flag := 1) and opcode 0x07 GO (halt flag := 0).
REQ-022 SHALL ignore any other opcode and return to idle.
REQ-023 SHALL drive csu = halt flag OR a memory access in progress; csu SHALL be 1 in the cycle before, during and after every ru or wru cycle.
REQ-024 SHALL hold addru and datau stable throughout every ru or wru cycle.
REQ-025 SHALL never assert ru and a nonzero wru in the same cycle.
REQ-026 SHALL keep od valid in the cycle dox=1 and unchanged until the next dox.
REQ-027 SHALL wait after each dox at least GAP cycles before the next dox; the first response byte MAY be sent as soon as it is ready if no gap is pending.
REQ-028 SHALL ignore dix while transmitting a response or performing an access.
REQ-029 SHALL let addru wrap modulo 2^16: 0xFFFF+1=0x0000 and 0xFFFE+2=0x0000.
REQ-030 SHALL keep operand state across arbitrary idle gaps between bytes (no timeout).

Reset
REQ-031 SHALL, while reset=1 at a clock edge, set csu=0, addru=0, datau=0, ru=0, wru=0, dox=0, od=0, clear the halt flag, return to idle, and clear the gap counter.
REQ-032 SHALL, on reset mid-command or mid-transmission, discard the partial command and send no further bytes.

Verification
REQ-033 SHALL pass: bytes 01 12 34 -> addru=0x1234, no ru/wru pulse.
REQ-034 SHALL pass: 01 00 10, 02 AB CD -> one cycle wru=11, addru=0x0010, datau=0xABCD, csu=1; then addru=0x0012.
REQ-035 SHALL pass: 01 00 11, 03 5A -> one cycle wru=01, datau=0x5A5A; then addru=0x0012.
REQ-036 SHALL pass: 01 20 00, 04 with data=0xBEEF -> one ru pulse; dox bytes BE then EF at least GAP cycles apart; addru=0x2002.
REQ-037 SHALL pass: 06, 05 with status=0x21 -> csu stays 1; byte 0x21 sent; then 07 -> csu=0.
REQ-038 SHALL pass: 01 FF FF, 03 77 -> wru=01; addru wraps to 0x0000.
